// File: rtl/fp_result_checker_pkg.sv
// Shared types, constants and helpers for the fp_unit result checker.
package fp_result_checker_pkg;

    localparam int unsigned FP_DATA_W  = 64;
    localparam int unsigned FP_FLAGS_W = 5;
    localparam int unsigned FP_FMT_W   = 2;
    localparam int unsigned FP_OP_W    = 10;
    localparam int unsigned FP_CNT_W   = 32;

    // Canonical quiet NaNs produced by fp_unit
    localparam logic [31:0] FP_QNAN_S = 32'h7FC0_0000;
    localparam logic [63:0] FP_QNAN_D = 64'h7FF8_0000_0000_0000;

    // Opcodes whose result is an integer/compare value and must match bit-exactly
    // (bit9 fcvt_f2i, bit6 fcmp)
    localparam logic [FP_OP_W-1:0] FP_OP_BITEXACT_MASK = 10'h240;

    // One expected result entry issued alongside an fp_unit operation
    typedef struct packed {
        logic [FP_DATA_W-1:0]  result;
        logic [FP_FLAGS_W-1:0] flags;
        logic [FP_FMT_W-1:0]   fmt;
        logic [FP_OP_W-1:0]    opcode;
    } fp_check_entry_type;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_PASS  = 3'd2,
        ST_FAIL  = 3'd3,
        ST_ERROR = 3'd4
    } fp_check_state_type;

    // Verdict states hold until reset
    function automatic logic fp_check_is_terminal(input fp_check_state_type s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_ERROR);
    endfunction

    // Result XOR, masked down to sign-less exponent+quiet bit when the calculated
    // value is the canonical NaN, so any reference NaN payload is accepted
    function automatic logic [FP_DATA_W-1:0] fp_check_masked_diff(
        input fp_check_entry_type    e,
        input logic [FP_DATA_W-1:0]  res
    );
        logic                 nan_ok;
        logic [FP_DATA_W-1:0] diff;
        nan_ok = ((e.opcode & FP_OP_BITEXACT_MASK) == '0);
        diff   = res ^ e.result;
        if (nan_ok && (e.fmt == '0) && (res[31:0] == FP_QNAN_S)) begin
            diff = {32'h0, 1'b0, res[30:22] ^ e.result[30:22], 22'h0};
        end else if (nan_ok && (e.fmt != '0) && (res == FP_QNAN_D)) begin
            diff = {1'b0, res[62:51] ^ e.result[62:51], 51'h0};
        end
        return diff;
    endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// Synchronous FIFO of expected entries; DEPTH must be a power of two >= 2.
module fp_check_fifo
    import fp_result_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_push,
    input  fp_check_entry_type i_push_data,
    input  logic               i_pop,
    output fp_check_entry_type o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    fp_check_entry_type r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Pointers carry a wrap bit so full and empty are distinguishable
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/fp_result_checker.sv
// Scoreboard for fp_unit: queues expected entries, compares one per ready pulse,
// counts pass/fail, captures the first mismatch and reports a final verdict.
module fp_result_checker
    import fp_result_checker_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [FP_DATA_W-1:0]  exp_result,
    input  logic [FP_FLAGS_W-1:0] exp_flags,
    input  logic [FP_FMT_W-1:0]   exp_fmt,
    input  logic [FP_OP_W-1:0]    exp_opcode,
    input  logic                  res_ready,
    input  logic [FP_DATA_W-1:0]  res_result,
    input  logic [FP_FLAGS_W-1:0] res_flags,
    input  logic                  done,
    output logic [FP_CNT_W-1:0]   pass_count,
    output logic [FP_CNT_W-1:0]   fail_count,
    output logic                  fail_valid,
    output logic [FP_DATA_W-1:0]  fail_result_diff,
    output logic [FP_FLAGS_W-1:0] fail_flags_diff,
    output logic [FP_DATA_W-1:0]  fail_ref,
    output logic [FP_DATA_W-1:0]  fail_calc,
    output logic                  finished,
    output logic                  passed,
    output logic                  proto_err
);

    fp_check_state_type r_state;
    fp_check_state_type w_next_state;

    logic                  r_accept_en;
    logic [FP_CNT_W-1:0]   r_pass_count;
    logic [FP_CNT_W-1:0]   r_fail_count;
    logic                  r_fail_valid;
    logic [FP_DATA_W-1:0]  r_fail_result_diff;
    logic [FP_FLAGS_W-1:0] r_fail_flags_diff;
    logic [FP_DATA_W-1:0]  r_fail_ref;
    logic [FP_DATA_W-1:0]  r_fail_calc;
    logic                  r_finished;
    logic                  r_passed;
    logic                  r_proto_err;

    fp_check_entry_type    w_push_entry;
    fp_check_entry_type    w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_active;
    logic                  w_push;
    logic                  w_pop;
    logic [FP_DATA_W-1:0]  w_result_diff;
    logic [FP_FLAGS_W-1:0] w_flags_diff;
    logic                  w_mismatch;

    assign w_push_entry = '{result: exp_result, flags: exp_flags,
                            fmt: exp_fmt, opcode: exp_opcode};

    // Expected-entry queue
    fp_check_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Handshake and compare of the head entry against the current result
    assign w_active      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign exp_ready     = r_accept_en && !w_full;
    assign w_push        = exp_valid && exp_ready;
    assign w_pop         = w_active && res_ready && !w_empty;
    assign w_result_diff = fp_check_masked_diff(w_head, res_result);
    assign w_flags_diff  = res_flags ^ w_head.flags;
    assign w_mismatch    = (w_result_diff != '0) || (w_flags_diff != '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_next_state;
    end

    // Next-state: protocol error first, then stop-on-fail, then done/drain verdict
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN, ST_DRAIN: begin
                if (res_ready && w_empty) begin
                    w_next_state = ST_ERROR;
                end else if (w_pop && w_mismatch && STOP_ON_FAIL) begin
                    w_next_state = ST_FAIL;
                end else if (r_state == ST_RUN) begin
                    if (done) w_next_state = ST_DRAIN;
                end else if (w_empty && !res_ready) begin
                    w_next_state = (r_fail_count == '0) ? ST_PASS : ST_FAIL;
                end
            end
            default: w_next_state = r_state;
        endcase
    end

    // Verdict outputs and push enable, registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_accept_en <= 1'b0;
            r_finished  <= 1'b0;
            r_passed    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_accept_en <= !fp_check_is_terminal(w_next_state);
            r_finished  <= fp_check_is_terminal(w_next_state);
            r_passed    <= (w_next_state == ST_PASS);
            if (w_next_state == ST_ERROR) r_proto_err <= 1'b1;
        end
    end

    // Saturating counters and first-mismatch capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pass_count       <= '0;
            r_fail_count       <= '0;
            r_fail_valid       <= 1'b0;
            r_fail_result_diff <= '0;
            r_fail_flags_diff  <= '0;
            r_fail_ref         <= '0;
            r_fail_calc        <= '0;
        end else if (w_pop) begin
            if (!w_mismatch) begin
                if (r_pass_count != '1) r_pass_count <= r_pass_count + FP_CNT_W'(1);
            end else begin
                if (r_fail_count != '1) r_fail_count <= r_fail_count + FP_CNT_W'(1);
                if (!r_fail_valid) begin
                    r_fail_valid       <= 1'b1;
                    r_fail_result_diff <= w_result_diff;
                    r_fail_flags_diff  <= w_flags_diff;
                    r_fail_ref         <= w_head.result;
                    r_fail_calc        <= res_result;
                end
            end
        end
    end

    assign pass_count       = r_pass_count;
    assign fail_count       = r_fail_count;
    assign fail_valid       = r_fail_valid;
    assign fail_result_diff = r_fail_result_diff;
    assign fail_flags_diff  = r_fail_flags_diff;
    assign fail_ref         = r_fail_ref;
    assign fail_calc        = r_fail_calc;
    assign finished         = r_finished;
    assign passed           = r_passed;
    assign proto_err        = r_proto_err;

endmodule

// File: tb/tb_fp_result_checker.sv
// Randomised scoreboard bench for fp_result_checker with a queue-based reference model.
module tb_fp_result_checker;
    import fp_result_checker_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [9:0] OP_FADD = 10'h001;
    localparam logic [9:0] OP_FMUL = 10'h004;
    localparam logic [9:0] OP_FDIV = 10'h008;
    localparam logic [9:0] OP_FCVT = 10'h200;
    localparam int T_NONE = 0, T_PASS = 1, T_FAIL = 2, T_ERR = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exp_valid = 1'b0, exp_ready;
    logic [63:0] exp_result = '0;
    logic [4:0]  exp_flags = '0;
    logic [1:0]  exp_fmt = '0;
    logic [9:0]  exp_opcode = '0;
    logic        res_ready = 1'b0;
    logic [63:0] res_result = '0;
    logic [4:0]  res_flags = '0;
    logic        done = 1'b0;
    logic [31:0] pass_count, fail_count;
    logic        fail_valid, finished, passed, proto_err;
    logic [63:0] fail_result_diff, fail_ref, fail_calc;
    logic [4:0]  fail_flags_diff;

    always #5 clock = ~clock;

    fp_result_checker #(.DEPTH(DEPTH), .STOP_ON_FAIL(1'b1)) dut (
        .reset(reset), .clock(clock),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_result(exp_result), .exp_flags(exp_flags),
        .exp_fmt(exp_fmt), .exp_opcode(exp_opcode),
        .res_ready(res_ready), .res_result(res_result), .res_flags(res_flags),
        .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .fail_valid(fail_valid),
        .fail_result_diff(fail_result_diff), .fail_flags_diff(fail_flags_diff),
        .fail_ref(fail_ref), .fail_calc(fail_calc),
        .finished(finished), .passed(passed), .proto_err(proto_err)
    );

    typedef struct {
        logic [31:0] pass_c;
        logic [31:0] fail_c;
        logic        fvalid;
        logic [63:0] fdiff;
        logic [4:0]  fflags;
        logic [63:0] fref;
        logic [63:0] fcalc;
        logic [2:0]  verdict; // {finished, passed, proto_err}
    } snap_t;

    snap_t              sb_q[$];
    fp_check_entry_type m_q[$];
    logic [31:0]        m_pass, m_fail;
    logic               m_fvalid, m_perr, m_drain;
    logic [63:0]        m_fdiff, m_fref, m_fcalc;
    logic [4:0]         m_fflags;
    int                 m_term;
    int                 n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic fp_check_entry_type mk(input logic [63:0] r, input logic [4:0] f,
                                              input logic [1:0] fm, input logic [9:0] op);
        fp_check_entry_type e;
        e.result = r; e.flags = f; e.fmt = fm; e.opcode = op;
        return e;
    endfunction

    // Reference diff: canonical NaN result tolerates any NaN payload in the reference
    function automatic logic [63:0] ref_diff(input fp_check_entry_type e, input logic [63:0] res);
        logic        strict;
        logic [63:0] x;
        strict = e.opcode[9] || e.opcode[6];
        x = res ^ e.result;
        if (!strict && e.fmt == 2'd0 && res[31:0] == 32'h7FC0_0000) return x & 64'h0000_0000_7FC0_0000;
        if (!strict && e.fmt != 2'd0 && res == 64'h7FF8_0000_0000_0000) return x & 64'h7FF8_0000_0000_0000;
        return x;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_fvalid = 0; m_perr = 0; m_drain = 0;
        m_fdiff = 0; m_fref = 0; m_fcalc = 0; m_fflags = 0; m_term = T_NONE;
    endtask

    // One clock of stimulus; model updated from pre-edge state, snapshot queued on res_ready
    task automatic cycle(input logic v, input fp_check_entry_type e, input logic rr,
                         input logic [63:0] rres, input logic [4:0] rfl, input logic dn,
                         output logic acc);
        fp_check_entry_type h;
        logic [63:0] d;
        logic [4:0]  fd;
        snap_t       s;
        exp_valid = v; exp_result = e.result; exp_flags = e.flags;
        exp_fmt = e.fmt; exp_opcode = e.opcode;
        res_ready = rr; res_result = rres; res_flags = rfl; done = dn;
        @(negedge clock);
        acc = (m_term == T_NONE) && (m_q.size() < DEPTH);
        if (v) chk("exp_ready", {63'h0, exp_ready}, {63'h0, acc});
        if (m_term == T_NONE) begin
            if (rr) begin
                if (m_q.size() == 0) begin
                    m_term = T_ERR; m_perr = 1;
                end else begin
                    h = m_q.pop_front();
                    d = ref_diff(h, rres);
                    fd = rfl ^ h.flags;
                    if (d == 0 && fd == 0) begin
                        if (m_pass != 32'hFFFF_FFFF) m_pass++;
                    end else begin
                        if (m_fail != 32'hFFFF_FFFF) m_fail++;
                        if (!m_fvalid) begin
                            m_fvalid = 1; m_fdiff = d; m_fflags = fd; m_fref = h.result; m_fcalc = rres;
                        end
                        m_term = T_FAIL;
                    end
                end
            end
            if (m_term == T_NONE) begin
                if (m_drain) begin
                    if (!rr && m_q.size() == 0) m_term = (m_fail == 0) ? T_PASS : T_FAIL;
                end else if (dn) begin
                    m_drain = 1;
                end
            end
            if (v && acc) m_q.push_back(e);
        end
        if (rr) begin
            s.pass_c = m_pass; s.fail_c = m_fail; s.fvalid = m_fvalid; s.fdiff = m_fdiff;
            s.fflags = m_fflags; s.fref = m_fref; s.fcalc = m_fcalc;
            s.verdict = {m_term != T_NONE, m_term == T_PASS, m_perr};
            sb_q.push_back(s);
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        logic a;
        cycle(0, '0, 0, '0, '0, 0, a);
    endtask

    task automatic push(input fp_check_entry_type e);
        logic a;
        cycle(1, e, 0, '0, '0, 0, a);
    endtask

    task automatic pop(input logic [63:0] r, input logic [4:0] f, input logic dn);
        logic a;
        cycle(0, '0, 1, r, f, dn, a);
    endtask

    task automatic do_reset();
        exp_valid = 0; res_ready = 0; done = 0; reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_bits", {59'h0, exp_ready, fail_valid, finished, passed, proto_err}, 64'h0);
        chk("rst_counts", {pass_count, fail_count}, 64'h0);
        chk("rst_capture", fail_result_diff | fail_ref | fail_calc | {59'h0, fail_flags_diff}, 64'h0);
        @(posedge clock); #1;
        reset = 0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        chk("ready_after_rst", {63'h0, exp_ready}, 64'h1);
        @(posedge clock); #1;
    endtask

    task automatic wait_verdict(input string name);
        int k;
        k = 0;
        while (!finished && k < 20) begin idle(); k++; end
        chk({name, "_finished"}, {63'h0, finished}, {63'h0, m_term != T_NONE});
        chk({name, "_passed"}, {63'h0, passed}, {63'h0, m_term == T_PASS});
        chk({name, "_proto"}, {63'h0, proto_err}, {63'h0, m_perr});
    endtask

    // Monitor: compare counters/capture one cycle after every res_ready
    initial begin
        logic  v;
        snap_t s;
        forever begin
            @(posedge clock);
            v = res_ready && !reset;
            @(negedge clock);
            if (v) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got result with no expected snapshot");
                end else begin
                    s = sb_q.pop_front();
                    chk("pass_count", {32'h0, pass_count}, {32'h0, s.pass_c});
                    chk("fail_count", {32'h0, fail_count}, {32'h0, s.fail_c});
                    chk("fail_valid", {63'h0, fail_valid}, {63'h0, s.fvalid});
                    chk("fail_result_diff", fail_result_diff, s.fdiff);
                    chk("fail_flags_diff", {59'h0, fail_flags_diff}, {59'h0, s.fflags});
                    chk("fail_ref_calc", fail_ref ^ {fail_calc[31:0], fail_calc[63:32]},
                        s.fref ^ {s.fcalc[31:0], s.fcalc[63:32]});
                    chk("verdict_bits", {61'h0, finished, passed, proto_err}, {61'h0, s.verdict});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        fp_check_entry_type ents[20];
        logic a;
        int p;

        // Basic single-precision pass then PASS verdict
        do_reset();
        push(mk(64'h3F80_0000, 5'h00, 2'd0, OP_FADD));
        pop(64'h3F80_0000, 5'h00, 0);
        pop(64'h0, 5'h00, 1'b0); // extra res_ready with empty queue would error; replaced below
        wait_verdict("basic_err");

        do_reset();
        push(mk(64'h3F80_0000, 5'h00, 2'd0, OP_FADD));
        pop(64'h3F80_0000, 5'h00, 0);
        cycle(0, '0, 0, '0, '0, 1, a);
        wait_verdict("basic_pass");

        // Canonical NaN masking, then bit-exact fcvt fails
        do_reset();
        push(mk(64'h7FC0_0001, 5'h00, 2'd0, OP_FMUL));
        push(mk(64'h7FC0_0001, 5'h00, 2'd0, OP_FCVT));
        pop(64'h7FC0_0000, 5'h00, 0);
        pop(64'h7FC0_0000, 5'h00, 0);
        wait_verdict("snan_fcvt");

        // Double canonical NaN vs infinity reference: quiet bit differs
        do_reset();
        push(mk(64'h7FF0_0000_0000_0000, 5'h00, 2'd1, OP_FDIV));
        pop(64'h7FF8_0000_0000_0000, 5'h00, 0);
        wait_verdict("dnan");

        // Flags-only mismatch; afterwards inputs are ignored
        do_reset();
        push(mk(64'h4000_0000, 5'h01, 2'd0, OP_FADD));
        push(mk(64'h4040_0000, 5'h00, 2'd0, OP_FADD));
        pop(64'h4000_0000, 5'h00, 0);
        cycle(1, mk(64'h1, 5'h0, 2'd0, OP_FADD), 1, 64'h4040_0000, 5'h00, 0, a);
        wait_verdict("flags_only");

        // Fill, push-while-full rejected, wrap with order preserved over 20 entries
        do_reset();
        for (int i = 0; i < 20; i++)
            ents[i] = mk({$urandom, $urandom}, 5'($urandom_range(0, 31)), 2'd1, OP_FADD);
        for (int i = 0; i < 8; i++) push(ents[i]);
        @(negedge clock);
        chk("full_ready_low", {63'h0, exp_ready}, 64'h0);
        @(posedge clock); #1;
        p = 8;
        cycle(1, ents[p], 1, m_q[0].result, m_q[0].flags, 0, a);
        if (a) p++;
        while (m_q.size() > 0 && m_term == T_NONE) begin
            cycle(p < 20, (p < 20) ? ents[p] : ents[0], ($urandom_range(0, 2) != 0),
                  m_q[0].result, m_q[0].flags, 0, a);
            if (a && p < 20) p++;
        end
        chk("fill_all_pushed", 64'(p), 64'd20);
        cycle(0, '0, 0, '0, '0, 1, a);
        wait_verdict("wrap");

        // Result with empty queue is a protocol error
        do_reset();
        pop(64'h0, 5'h0, 0);
        wait_verdict("proto");

        // Reset mid-queue discards entries and counters
        do_reset();
        push(mk(64'hA, 5'h0, 2'd1, OP_FADD));
        push(mk(64'hB, 5'h0, 2'd1, OP_FADD));
        push(mk(64'hC, 5'h0, 2'd1, OP_FADD));
        pop(64'hA, 5'h0, 0);
        do_reset();
        push(mk(64'h1234, 5'h2, 2'd1, OP_FMUL));
        pop(64'h1234, 5'h2, 0);
        pop(64'h0, 5'h0, 0);
        wait_verdict("midreset");

        // Randomised rounds: NaN payloads, strict opcodes, occasional corruption
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int c = 0; c < 150 && m_term == T_NONE; c++) begin
                fp_check_entry_type e, h;
                logic [63:0] r;
                logic [4:0]  f;
                logic        rr;
                e.fmt = 2'($urandom_range(0, 3));
                e.opcode = 10'(1) << $urandom_range(0, 9);
                e.flags = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) e.result = {$urandom, $urandom};
                else if (e.fmt == 2'd0) e.result = {32'h0, 32'h7FC0_0000 | 32'($urandom_range(0, 32'h3F_FFFF))};
                else e.result = 64'h7FF8_0000_0000_0000 | {13'h0, 19'($urandom), $urandom};
                rr = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
                r = 0; f = 0;
                if (rr) begin
                    h = m_q[0];
                    r = h.result; f = h.flags;
                    case ($urandom_range(0, 19))
                        0: r = r ^ (64'h1 << $urandom_range(0, 63));
                        1: f = f ^ (5'h1 << $urandom_range(0, 4));
                        2, 3, 4, 5: r = (h.fmt == 2'd0) ? {32'($urandom), 32'h7FC0_0000}
                                                         : 64'h7FF8_0000_0000_0000;
                        default: ;
                    endcase
                end
                cycle($urandom_range(0, 1) == 1, e, rr, r, f, 0, a);
            end
            if (m_term == T_NONE) begin
                cycle(0, '0, 0, '0, '0, 1, a);
                while (m_q.size() > 0 && m_term == T_NONE)
                    pop(m_q[0].result, m_q[0].flags, 0);
            end
            wait_verdict("random");
        end

        repeat (3) idle();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
